// File: rtl/isp_param_pkg.sv
// rtl/isp_param_pkg.sv - shared constants and commit FSM state type for isp_param_ctrl
package isp_param_pkg;

  // Register word offsets within the decoded low address window
  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_STG0   = 8'h04;
  localparam logic [7:0] OFS_STG1   = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_IRQ    = 8'h10;

  // CTRL register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_COMMIT  = 1;
  localparam int CTRL_CNT_CLR = 2;
  localparam int CTRL_MASK_LO = 4;
  localparam int CTRL_MASK_HI = 5;

  // IRQ flag bit positions
  localparam int IRQ_FRAME_DONE = 0;
  localparam int IRQ_APPLY      = 1;

  // Only full-word writes are honoured
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Commit sequencing: staging is handed to the pipeline only on a frame boundary
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } commit_state_e;

endpackage

// File: rtl/isp_param_ahb_if.sv
// rtl/isp_param_ahb_if.sv - AHB-Lite address/data phase capture, write strobes and read mux
module isp_param_ahb_if
  import isp_param_pkg::*;
#(
  parameter int ADDR_LSB_W = 5
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] ctrl_rdata_i,
  input  logic [31:0] stg0_rdata_i,
  input  logic [31:0] stg1_rdata_i,
  input  logic [31:0] status_rdata_i,
  input  logic [31:0] irq_rdata_i,
  output logic        we_ctrl_o,
  output logic        we_stg0_o,
  output logic        we_stg1_o,
  output logic        we_irq_o,
  output logic [31:0] rdata_o
);

  logic                  dphase_q;
  logic [ADDR_LSB_W-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [7:0]            addr_ofs;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  unused_haddr;

  // Upper address bits alias onto the decoded window
  assign unused_haddr = ^HADDR[31:ADDR_LSB_W];

  // Capture the address phase; the data phase lasts exactly one cycle (zero wait)
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
    end else if (HREADY) begin
      dphase_q <= HSEL & HTRANS[1];
      if (HSEL & HTRANS[1]) begin
        addr_q  <= HADDR[ADDR_LSB_W-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  assign addr_ofs = 8'(addr_q);
  assign wr_ok    = dphase_q & write_q & (size_q == HSIZE_WORD);
  assign rd_ok    = dphase_q & ~write_q;

  assign we_ctrl_o = wr_ok & (addr_ofs == OFS_CTRL);
  assign we_stg0_o = wr_ok & (addr_ofs == OFS_STG0);
  assign we_stg1_o = wr_ok & (addr_ofs == OFS_STG1);
  assign we_irq_o  = wr_ok & (addr_ofs == OFS_IRQ);

  // Read data is driven only during a read data phase, zero otherwise
  always_comb begin
    rdata_o = '0;
    if (rd_ok) begin
      case (addr_ofs)
        OFS_CTRL:   rdata_o = ctrl_rdata_i;
        OFS_STG0:   rdata_o = stg0_rdata_i;
        OFS_STG1:   rdata_o = stg1_rdata_i;
        OFS_STATUS: rdata_o = status_rdata_i;
        OFS_IRQ:    rdata_o = irq_rdata_i;
        default:    rdata_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/isp_param_ctrl.sv
// rtl/isp_param_ctrl.sv - ISP parameter staging/commit controller; optional IRQ via ISP_PARAM_IRQ_EN
module isp_param_ctrl
  import isp_param_pkg::*;
#(
  parameter int FCNT_W     = 16,
  parameter int ADDR_LSB_W = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic              frame_start,
  input  logic              frame_done,
  output logic              isp_en,
  output logic [31:0]       param0,
  output logic [31:0]       param1,
  output logic              param_update,
  output logic [FCNT_W-1:0] frames_cnt
`ifdef ISP_PARAM_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic              en_q;
  logic [31:0]       stg0_q;
  logic [31:0]       stg1_q;
  logic [31:0]       p0_q;
  logic [31:0]       p1_q;
  logic [FCNT_W-1:0] cnt_q;
  commit_state_e     state_q;

  logic              we_ctrl;
  logic              we_stg0;
  logic              we_stg1;
  logic              we_irq;
  logic              commit_wr;
  logic              cnt_clr;
  logic              apply_go;
  logic              frame_cnt_evt;
  logic [31:0]       ctrl_rdata;
  logic [31:0]       status_rdata;
  logic [31:0]       irq_rdata;

  isp_param_ahb_if #(
    .ADDR_LSB_W(ADDR_LSB_W)
  ) u_ahb_if (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .HSEL           (HSEL),
    .HADDR          (HADDR),
    .HTRANS         (HTRANS),
    .HWRITE         (HWRITE),
    .HSIZE          (HSIZE),
    .HREADY         (HREADY),
    .ctrl_rdata_i   (ctrl_rdata),
    .stg0_rdata_i   (stg0_q),
    .stg1_rdata_i   (stg1_q),
    .status_rdata_i (status_rdata),
    .irq_rdata_i    (irq_rdata),
    .we_ctrl_o      (we_ctrl),
    .we_stg0_o      (we_stg0),
    .we_stg1_o      (we_stg1),
    .we_irq_o       (we_irq),
    .rdata_o        (HRDATA)
  );

  assign commit_wr     = we_ctrl & HWDATA[CTRL_COMMIT];
  assign cnt_clr       = we_ctrl & HWDATA[CTRL_CNT_CLR];
  assign apply_go      = (state_q == ST_ARMED) & frame_start & en_q;
  assign frame_cnt_evt = frame_done & en_q;

  // Enable bit and staging words; a staging write on the load edge lands after the load
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q   <= 1'b0;
      stg0_q <= '0;
      stg1_q <= '0;
    end else begin
      if (we_ctrl) en_q   <= HWDATA[CTRL_EN];
      if (we_stg0) stg0_q <= HWDATA;
      if (we_stg1) stg1_q <= HWDATA;
    end
  end

  // Commit FSM: arm on commit, load active params on the next enabled frame_start
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      p0_q    <= '0;
      p1_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (commit_wr) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (apply_go) begin
            state_q <= ST_APPLY;
            p0_q    <= stg0_q;
            p1_q    <= stg1_q;
          end
        end
        ST_APPLY: begin
          state_q <= commit_wr ? ST_ARMED : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Completed-frame counter; software clear has priority over a same-cycle increment
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (frame_cnt_evt) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign status_rdata = (32'(cnt_q) << 16)
                      | {30'd0, state_q == ST_APPLY, state_q == ST_ARMED};

`ifdef ISP_PARAM_IRQ_EN
  logic [1:0] mask_q;
  logic [1:0] flags_q;
  logic [1:0] flags_d;
  logic       irq_q;

  // Interrupt mask lives in CTRL[5:4]
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_q <= '0;
    end else if (we_ctrl) begin
      mask_q <= HWDATA[CTRL_MASK_HI:CTRL_MASK_LO];
    end
  end

  // Flag next-state: W1C first, then hardware set so a set wins over a clear
  always_comb begin
    flags_d = flags_q & ~(we_irq ? HWDATA[1:0] : 2'b00);
    if (frame_cnt_evt) flags_d[IRQ_FRAME_DONE] = 1'b1;
    if (apply_go)      flags_d[IRQ_APPLY]      = 1'b1;
  end

  // Flags and a registered, masked interrupt output
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      flags_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      irq_q   <= |(flags_q & mask_q);
    end
  end

  assign irq        = irq_q;
  assign ctrl_rdata = {26'd0, mask_q, 3'd0, en_q};
  assign irq_rdata  = {30'd0, flags_q};
`else
  assign ctrl_rdata = {31'd0, en_q};
  assign irq_rdata  = '0;
`endif

  assign isp_en       = en_q;
  assign param0       = p0_q;
  assign param1       = p1_q;
  assign param_update = (state_q == ST_APPLY);
  assign frames_cnt   = cnt_q;
  assign HREADYOUT    = 1'b1;
  assign HRESP        = 1'b0;

endmodule

// File: tb/tb_isp_param_ctrl.sv
// tb/tb_isp_param_ctrl.sv - randomized self-checking bench for isp_param_ctrl
module tb_isp_param_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        frame_start;
  logic        frame_done;
  logic        isp_en;
  logic [31:0] param0;
  logic [31:0] param1;
  logic        param_update;
  logic [15:0] frames_cnt;
`ifdef ISP_PARAM_IRQ_EN
  logic        irq;
`endif

  int checks;
  int errors;

  // Reference model state, kept in register-map terms
  bit          m_en;
  bit [1:0]    m_mask;
  bit [31:0]   m_stg0;
  bit [31:0]   m_stg1;
  bit [31:0]   m_p0;
  bit [31:0]   m_p1;
  bit          m_pending;
  int unsigned m_cnt;
  bit [1:0]    m_flags;

  isp_param_ctrl #(.FCNT_W(16), .ADDR_LSB_W(5)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HSEL         (HSEL),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HWRITE       (HWRITE),
    .HSIZE        (HSIZE),
    .HREADY       (HREADY),
    .HWDATA       (HWDATA),
    .HRDATA       (HRDATA),
    .HREADYOUT    (HREADYOUT),
    .HRESP        (HRESP),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .isp_en       (isp_en),
    .param0       (param0),
    .param1       (param1),
    .param_update (param_update),
    .frames_cnt   (frames_cnt)
`ifdef ISP_PARAM_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic void model_reset();
    m_en = 0; m_mask = 0; m_stg0 = 0; m_stg1 = 0; m_p0 = 0; m_p1 = 0;
    m_pending = 0; m_cnt = 0; m_flags = 0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    if (sz != 3'b010) return;
    case (a[4:0])
      5'h00: begin
        m_en = d[0];
`ifdef ISP_PARAM_IRQ_EN
        m_mask = d[5:4];
`endif
        if (d[2]) m_cnt = 0;
        if (d[1]) m_pending = 1;
      end
      5'h04: m_stg0 = d;
      5'h08: m_stg1 = d;
`ifdef ISP_PARAM_IRQ_EN
      5'h10: m_flags = m_flags & ~d[1:0];
`endif
      default: ;
    endcase
  endfunction

  function automatic void model_frame_start();
    if (m_pending && m_en) begin
      m_p0 = m_stg0; m_p1 = m_stg1; m_pending = 0;
      m_flags[1] = 1;
    end
  endfunction

  function automatic void model_frame_done();
    if (m_en) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_flags[0] = 1;
    end
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] r;
    r = 0;
    case (a[4:0])
      5'h00: r = {26'd0, m_mask, 3'd0, m_en};
      5'h04: r = m_stg0;
      5'h08: r = m_stg1;
      5'h0C: r = (m_cnt << 16) | {31'd0, m_pending};
`ifdef ISP_PARAM_IRQ_EN
      5'h10: r = {30'd0, m_flags};
`endif
      default: r = 0;
    endcase
    return r;
  endfunction

  // Bus write; optional frame pulses in the address or data phase cycle. Starts and ends at a negedge.
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                           input logic fs_a, input logic fs_d, input logic fd_d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a; HSIZE = sz; frame_start = fs_a;
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d; frame_start = fs_d; frame_done = fd_d;
    @(negedge HCLK);
    frame_start = 0; frame_done = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ahb_write(a, d, 3'b010, 0, 0, 0);
    model_write(a, d, 3'b010);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a; HSIZE = 3'b010;
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00;
    #1 d = HRDATA;
    @(negedge HCLK);
  endtask

  task automatic pulse_fs();
    frame_start = 1;
    @(negedge HCLK);
    frame_start = 0;
    model_frame_start();
  endtask

  task automatic pulse_fd();
    frame_done = 1;
    @(negedge HCLK);
    frame_done = 0;
    model_frame_done();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] ofs [5];
    ofs[0] = 32'h00; ofs[1] = 32'h04; ofs[2] = 32'h08; ofs[3] = 32'h0C; ofs[4] = 32'h10;
    HRESETn = 0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 3'b010; HREADY = 1;
    HWDATA = 0; frame_start = 0; frame_done = 0;
    model_reset();
    repeat (3) @(negedge HCLK);
    checks++;
    if ({HRDATA, HREADYOUT, HRESP, isp_en, param0, param1, param_update, frames_cnt} !==
        {32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h rdyout=%b resp=%b en=%b p0=%h p1=%h upd=%b cnt=%h expected all zero, rdyout=1",
               HRDATA, HREADYOUT, HRESP, isp_en, param0, param1, param_update, frames_cnt);
    end
`ifdef ISP_PARAM_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
    HRESETn = 1;
    @(negedge HCLK);
    for (int i = 0; i < 5; i++) begin
      ahb_read(ofs[i], rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL reset_read_%h: got %h expected 00000000", ofs[i], rd);
      end
    end
  endtask

  task automatic test_commit_basic();
    logic [31:0] rd;
    wr(32'h00, 32'h1);
    wr(32'h04, 32'h23498701);
    wr(32'h08, 32'hAB9C8F00);
    wr(32'h00, 32'h3);
    ahb_read(32'h0C, rd);
    checks++;
    if (rd !== exp_read(32'h0C)) begin
      errors++; $display("FAIL commit_armed: got %h expected %h", rd, exp_read(32'h0C));
    end
    pulse_fs();
    checks++;
    if (param0 !== 32'h23498701 || param1 !== 32'hAB9C8F00 || param_update !== 1'b1) begin
      errors++;
      $display("FAIL commit_apply: got p0=%h p1=%h upd=%b expected p0=23498701 p1=AB9C8F00 upd=1",
               param0, param1, param_update);
    end
    @(negedge HCLK);
    checks++;
    if (param_update !== 1'b0) begin
      errors++; $display("FAIL commit_update_width: got upd=%b expected 0", param_update);
    end
    ahb_read(32'h0C, rd);
    checks++;
    if (rd[0] !== 1'b0) begin
      errors++; $display("FAIL commit_disarm: got status=%h expected bit0=0", rd);
    end
  endtask

  task automatic test_size();
    logic [31:0] rd;
    ahb_write(32'h04, 32'h1, 3'b000, 0, 0, 0);
    model_write(32'h04, 32'h1, 3'b000);
    ahb_read(32'h04, rd);
    checks++;
    if (rd !== m_stg0) begin
      errors++; $display("FAIL size_byte_ignored: got %h expected %h", rd, m_stg0);
    end
  endtask

  task automatic test_disabled();
    logic [31:0] rd;
    wr(32'h04, 32'h11112222);
    wr(32'h08, 32'h33334444);
    wr(32'h00, 32'h3);
    wr(32'h00, 32'h0);
    pulse_fs();
    pulse_fs();
    ahb_read(32'h0C, rd);
    checks++;
    if (param0 !== m_p0 || param1 !== m_p1 || rd[0] !== 1'b1) begin
      errors++;
      $display("FAIL disabled_hold: got p0=%h p1=%h armed=%b expected p0=%h p1=%h armed=1",
               param0, param1, rd[0], m_p0, m_p1);
    end
    wr(32'h00, 32'h1);
    pulse_fs();
    checks++;
    if (param0 !== 32'h11112222 || param1 !== 32'h33334444) begin
      errors++;
      $display("FAIL disabled_then_apply: got p0=%h p1=%h expected 11112222 33334444", param0, param1);
    end
  endtask

  task automatic test_edges();
    logic [31:0] rd;
    logic [31:0] old0;
    // Commit data phase on a frame_start cycle: that frame_start is not consumed
    wr(32'h04, 32'hA0A0A0A0);
    wr(32'h08, 32'hB0B0B0B0);
    old0 = m_p0;
    ahb_write(32'h00, 32'h3, 3'b010, 0, 1, 0);
    model_write(32'h00, 32'h3, 3'b010);
    ahb_read(32'h0C, rd);
    checks++;
    if (param0 !== old0 || rd[0] !== 1'b1) begin
      errors++; $display("FAIL edge_commit_on_fs: got p0=%h armed=%b expected p0=%h armed=1", param0, rd[0], old0);
    end
    pulse_fs();
    checks++;
    if (param0 !== 32'hA0A0A0A0 || param1 !== 32'hB0B0B0B0) begin
      errors++; $display("FAIL edge_commit_next_fs: got p0=%h p1=%h expected A0A0A0A0 B0B0B0B0", param0, param1);
    end
    // Commit landing in the APPLY cycle re-arms
    wr(32'h04, 32'hC1C1C1C1);
    wr(32'h00, 32'h3);
    ahb_write(32'h00, 32'h3, 3'b010, 1, 0, 0);
    model_frame_start();
    model_write(32'h00, 32'h3, 3'b010);
    ahb_read(32'h0C, rd);
    checks++;
    if (param0 !== 32'hC1C1C1C1 || rd[0] !== 1'b1) begin
      errors++; $display("FAIL edge_commit_in_apply: got p0=%h armed=%b expected p0=C1C1C1C1 armed=1", param0, rd[0]);
    end
    // Staging write on the load edge: active gets old staging, staging gets new
    ahb_write(32'h04, 32'hD2D2D2D2, 3'b010, 0, 1, 0);
    model_frame_start();
    model_write(32'h04, 32'hD2D2D2D2, 3'b010);
    ahb_read(32'h04, rd);
    checks++;
    if (param0 !== 32'hC1C1C1C1 || rd !== 32'hD2D2D2D2) begin
      errors++; $display("FAIL edge_stg_on_load: got p0=%h stg0=%h expected p0=C1C1C1C1 stg0=D2D2D2D2", param0, rd);
    end
    // Clear beats a same-cycle frame_done
    pulse_fd(); pulse_fd();
    ahb_write(32'h00, 32'h5, 3'b010, 0, 0, 1);
    model_frame_done();
    model_write(32'h00, 32'h5, 3'b010);
    checks++;
    if (frames_cnt !== 16'd0) begin
      errors++; $display("FAIL edge_clr_vs_done: got cnt=%h expected 0000", frames_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  sz;
    logic [4:0]  ofs_tab [8];
    ofs_tab[0] = 5'h00; ofs_tab[1] = 5'h04; ofs_tab[2] = 5'h08; ofs_tab[3] = 5'h0C;
    ofs_tab[4] = 5'h10; ofs_tab[5] = 5'h14; ofs_tab[6] = 5'h1C; ofs_tab[7] = 5'h01;
    for (int n = 0; n < 200; n++) begin
      a = {$urandom_range(0, 3) == 0 ? 27'($urandom) : 27'd0, ofs_tab[$urandom_range(0, 7)]};
      case ($urandom_range(0, 5))
        0, 1: begin
          d = $urandom;
          if (a[4:0] == 5'h00) d[0] = ($urandom_range(0, 3) != 0);
          sz = ($urandom_range(0, 4) < 3) ? 3'b010 : 3'($urandom_range(0, 1));
          ahb_write(a, d, sz, 0, 0, 0);
          model_write(a, d, sz);
        end
        2, 3: begin
          ahb_read(a, rd);
          checks++;
          if (rd !== exp_read(a)) begin
            errors++; $display("FAIL rand_read[%0d] addr=%h: got %h expected %h", n, a, rd, exp_read(a));
          end
`ifdef ISP_PARAM_IRQ_EN
          checks++;
          if (irq !== |(m_flags & m_mask)) begin
            errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq, |(m_flags & m_mask));
          end
`endif
        end
        4: begin
          pulse_fs();
          checks++;
          if (param0 !== m_p0 || param1 !== m_p1) begin
            errors++; $display("FAIL rand_params[%0d]: got %h %h expected %h %h", n, param0, param1, m_p0, m_p1);
          end
        end
        default: begin
          pulse_fd();
          checks++;
          if (frames_cnt !== 16'(m_cnt) || isp_en !== m_en) begin
            errors++; $display("FAIL rand_count[%0d]: got cnt=%h en=%b expected %h %b", n, frames_cnt, isp_en, 16'(m_cnt), m_en);
          end
        end
      endcase
    end
  endtask

`ifdef ISP_PARAM_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd;
    wr(32'h10, 32'h3);
    wr(32'h00, 32'h21);
    wr(32'h00, 32'h23);
    pulse_fs();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
    @(negedge HCLK);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
    wr(32'h10, 32'h2);
    @(negedge HCLK);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    wr(32'h00, 32'h11);
    ahb_write(32'h10, 32'h1, 3'b010, 0, 0, 1);
    model_frame_done();
    model_write(32'h10, 32'h1, 3'b010);
    ahb_read(32'h10, rd);
    checks++;
    if (rd !== exp_read(32'h10) || rd[0] !== 1'b1) begin
      errors++; $display("FAIL irq_set_beats_clr: got %h expected %h", rd, exp_read(32'h10));
    end
  endtask
`endif

  task automatic test_frame_count();
    logic [31:0] rd;
    wr(32'h00, 32'h5);
    frame_done = 1;
    repeat (65537) begin
      @(negedge HCLK);
      model_frame_done();
    end
    frame_done = 0;
    checks++;
    if (frames_cnt !== 16'(m_cnt) || frames_cnt !== 16'd1) begin
      errors++; $display("FAIL count_wrap: got %h expected 0001", frames_cnt);
    end
    ahb_read(32'h0C, rd);
    checks++;
    if (rd !== exp_read(32'h0C)) begin
      errors++; $display("FAIL count_status: got %h expected %h", rd, exp_read(32'h0C));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    wr(32'h04, 32'h5A5A5A5A);
    wr(32'h00, 32'h3);
    #2 HRESETn = 0;
    #1;
    checks++;
    if ({isp_en, param0, param1, param_update, frames_cnt, HRDATA} !== {1'b0, 32'd0, 32'd0, 1'b0, 16'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_async: got en=%b p0=%h p1=%h upd=%b cnt=%h expected all zero",
               isp_en, param0, param1, param_update, frames_cnt);
    end
    model_reset();
    @(negedge HCLK);
    HRESETn = 1;
    @(negedge HCLK);
    wr(32'h04, 32'h77777777);
    wr(32'h00, 32'h1);
    pulse_fs();
    ahb_read(32'h0C, rd);
    checks++;
    if (param0 !== 32'd0 || rd !== 32'd0) begin
      errors++; $display("FAIL reset_mid_commit_lost: got p0=%h status=%h expected 0 0", param0, rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_commit_basic();
    test_size();
    test_disabled();
    test_edges();
    test_random();
`ifdef ISP_PARAM_IRQ_EN
    test_irq();
`endif
    test_frame_count();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/isp_param_ctrl.md
# isp_param_ctrl

AHB-Lite slave that owns the ISP configuration registers and sequences their hand-off to the pixel pipeline. Software writes staging parameters and a commit request. The block transfers staging to active parameters only at the next frame boundary, so the ISP never sees a half-updated set. It also counts completed frames and gates ISP enable. It sits between the AHB interconnect and the ISP datapath inside the ISP subsystem.

## Interface
Parameters:
- FCNT_W, 16, frame counter width (≤16)
- ADDR_LSB_W, 5, decoded low address bits

Ports:
- HCLK  in  1  system clock; single clock domain
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address; only [ADDR_LSB_W-1:0] decoded
- HTRANS  in  2  transfer type; NONSEQ/SEQ = HTRANS[1]
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size; only 3'b010 (word) writes accepted
- HREADY  in  1  bus ready
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  read data (data phase)
- HREADYOUT  out  1  constant 1 (zero wait)
- HRESP  out  1  constant 0 (OKAY)
- frame_start  in  1  one-cycle pulse from ISP, synchronous to HCLK
- frame_done  in  1  one-cycle pulse from ISP
- isp_en  out  1  ISP enable
- param0  out  32  active parameter word 0
- param1  out  32  active parameter word 1
- param_update  out  1  one-cycle pulse after active load
- frames_cnt  out  FCNT_W  completed frames
- irq  out  1  interrupt; present only with ISP_PARAM_IRQ_EN

## Operation
- Register map (word offsets):
  - 0x00 CTRL: [0] enable; [1] commit, write-only, self-clearing, reads 0; [2] cnt_clr, write-only, reads 0; [5:4] irq mask.
  - 0x04 STG0: staging word 0, RW.
  - 0x08 STG1: staging word 1, RW.
  - 0x0C STATUS, RO: [0] armed; [1] applying; [31:16] frames_cnt, zero-extended.
  - 0x10 IRQ: [0] frame_done flag; [1] apply flag; write 1 to clear.
  - All other offsets read 0; writes to them are ignored.
- Address phase is captured when HSEL & HREADY & HTRANS[1]. The latched address, write flag and size are used in the next (data) cycle.
- Writes commit at the end of the data phase. Non-word writes are ignored.
- Reads are combinational from the latched address during the data phase.
- Commit FSM has three states: IDLE, ARMED, APPLY.
  - IDLE → ARMED on a commit write.
  - ARMED → APPLY on frame_start & isp_en. On that same edge, param0/param1 load STG0/STG1.
  - APPLY → IDLE after one cycle, or → ARMED if a commit write lands in the APPLY cycle.
  - A commit write in ARMED is a no-op.
- param_update = (state == APPLY).
- frames_cnt increments on frame_done & isp_en and wraps to 0 after all-ones.
- isp_en = CTRL[0].

## Timing
- Reset values of all outputs: HRDATA 0, HREADYOUT 1, HRESP 0, isp_en 0, param0 0, param1 0, param_update 0, frames_cnt 0, irq 0. FSM resets to IDLE; staging and flags reset to 0.
- Commit write data phase in cycle N → armed visible in cycle N+1.
- frame_start in cycle M (while ARMED, isp_en=1) → new param values and param_update=1 in cycle M+1 → param_update=0 in cycle M+2.
- Commit data phase coinciding with a frame_start cycle: that frame_start is not consumed. The commit applies at the following frame_start.
- Staging write coinciding with the frame_start load edge: active takes the old staging value; staging takes the new one.
- frame_start while isp_en=0: ignored; the FSM stays ARMED.
- cnt_clr and frame_done in the same cycle: clear wins, count = 0.
- Clearing enable while ARMED keeps the FSM ARMED.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). A pending commit is lost.

## Configuration
- ISP_PARAM_IRQ_EN defined:
  - The IRQ register and irq port exist.
  - Flags set on frame_done & isp_en (bit0) and on entry to APPLY (bit1).
  - Set beats a W1C clear in the same cycle.
  - irq = |(flags & CTRL[5:4]), registered.
- ISP_PARAM_IRQ_EN undefined:
  - No irq port and no flag registers.
  - 0x10 reads 0; writes to 0x10 and to CTRL[5:4] are ignored.

## Structure
- Package isp_param_pkg holds:
  - register offset constants (OFS_CTRL, OFS_STG0, OFS_STG1, OFS_STATUS, OFS_IRQ);
  - CTRL bit-index constants;
  - the commit FSM state enum.
- One natural sub-module: isp_param_ahb_if, containing the AHB address/data-phase capture and the write-strobe/read-mux decode. The commit FSM, counter and IRQ logic stay in the top.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C/0x10 → all reads 0; HREADYOUT=1; param0/param1=0.
- Write CTRL=0x1, STG0=0x23498701, STG1=0xAB9C8F00, CTRL=0x3, then pulse frame_start → param0=0x23498701 and param1=0xAB9C8F00 one cycle later; param_update high exactly one cycle; STATUS[0] returns to 0.
- Write STG0=0x1 with HSIZE=3'b000 → STG0 unchanged on readback.
- Commit with isp_en=0, then pulse frame_start ×2 → params unchanged and STATUS[0]=1. Set enable, then pulse frame_start → params apply.
- Pulse frame_done 65537 times with enable=1 → frames_cnt=1. cnt_clr in the same cycle as frame_done → frames_cnt=0.
- With ISP_PARAM_IRQ_EN: mask=2'b10, then a commit and frame_start → irq=1 two cycles after frame_start. Write 0x10=0x2 → irq=0.
